// File: rtl/mem_port_arb.sv
// Memory port arbiter: shares one memory bus between instruction fetch and
// data access. Data has priority, a starvation counter forces fetch
// progress, and a lock keeps the bus on the data side across multi-beat
// block transfers and SWP.
//
// Handshake: a requester holds req (and its address/data) until its ack.
// The winner's request is latched at grant; o_bus_req rises the next cycle
// and stays high until the cycle i_bus_rdy is seen, which is also the ack
// cycle. One idle bubble follows every transaction.
module mem_port_arb #(
  parameter int FETCH_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_flush,
  output logic        o_if_ack,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [1:0]  i_d_size,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic        i_d_lock,
  output logic        o_d_ack,
  output logic [31:0] o_d_rdata,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [1:0]  o_bus_size,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rdy,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       lock_q;
  logic       flush_q;   // a flush was seen during the current fetch beat

  logic       fetch_ok;
  logic       grant_d;
  logic       grant_i;
  logic       grant_lock;

  assign fetch_ok = i_if_req & ~i_flush;

  // Arbitration in IDLE: lock, then forced fetch, then data, then fetch.
  always_comb begin
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    grant_lock = 1'b0;
    if (state == IDLE) begin
      if (lock_q && i_d_req) begin
        grant_d    = 1'b1;
        grant_lock = 1'b1;
      end else if (fetch_ok && (starve_cnt == STARVE_MAX)) begin
        grant_i = 1'b1;
      end else if (i_d_req) begin
        grant_d = 1'b1;
      end else if (fetch_ok) begin
        grant_i = 1'b1;
      end
    end
  end

  // Acks are combinational on the i_bus_rdy cycle; a flushed fetch never acks.
  always_comb begin
    o_d_ack    = (state == BUSY_D) && i_bus_rdy;
    o_if_ack   = (state == BUSY_I) && i_bus_rdy && !i_flush && !flush_q;
    o_d_rdata  = o_d_ack  ? i_bus_rdata : 32'd0;
    o_if_rdata = o_if_ack ? i_bus_rdata : 32'd0;
  end

  // Single FSM: grant latching, bus hold, completion, lock and starvation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      lock_q      <= 1'b0;
      flush_q     <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_size  <= 2'd0;
      o_bus_addr  <= 32'd0;
      o_bus_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_if_req) starve_cnt <= 4'd0;
          if (!i_d_req)  lock_q     <= 1'b0;
          if (grant_d) begin
            state       <= BUSY_D;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_d_we;
            o_bus_size  <= i_d_size;
            o_bus_addr  <= i_d_addr;
            o_bus_wdata <= i_d_wdata;
            // Locked beats belong to one transfer and do not starve fetch again.
            if (!grant_lock && i_if_req && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_i) begin
            state       <= BUSY_I;
            o_bus_req   <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_size  <= 2'd2;
            o_bus_addr  <= i_if_addr;
            o_bus_wdata <= 32'd0;
            starve_cnt  <= 4'd0;
            lock_q      <= 1'b0;
            flush_q     <= 1'b0;
          end
        end
        BUSY_I: begin
          if (i_flush) flush_q <= 1'b1;
          if (i_bus_rdy) begin
            state       <= IDLE;
            flush_q     <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_size  <= 2'd0;
            o_bus_addr  <= 32'd0;
            o_bus_wdata <= 32'd0;
          end
        end
        BUSY_D: begin
          if (i_bus_rdy) begin
            state       <= IDLE;
            lock_q      <= i_d_lock;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_size  <= 2'd0;
            o_bus_addr  <= 32'd0;
            o_bus_wdata <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
